data_ram_ws: RTL and testbench

- Wait-state data memory responder for the OpenMIPS load/store port; the slave end of the CPU's data-memory access.
- Stores 32-bit words in four byte banks. Supports byte-lane writes.
- Answers each request after a programmable number of wait cycles with a one-cycle ack.
- Raises a stall request so the CPU pipeline holds the access steady until it is answered.
- Sits in the min SOPC in place of the zero-latency data RAM, to exercise the pipeline stall paths.

---
 rtl/data_ram_ws.sv | 106 ++++++++++
 tb/tb_data_ram_ws.sv | 136 +++++++++++++
 2 files changed

// File: rtl/data_ram_ws.sv
// Wait-state data memory responder: a request latched in IDLE is answered WAIT_CYCLES+2 cycles later with a one-cycle ack.
// Dropping ce before the access edge aborts the request; stallreq_o holds the CPU pipeline until the ack.
module data_ram_ws #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        stallreq_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_idx;
   logic [3:0]              lat_sel;
   logic [31:0]             lat_dat;
   logic                    do_access;
   logic [7:0]              bank [0:3][0:DEPTH-1];
   logic                    addr_unused;

   // Address bits outside the word index alias onto the same word.
   assign addr_unused = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

   assign do_access  = (state == ST_ACCESS) && ce;
   assign ack_o      = (state == ST_DONE);
   assign stallreq_o = ce & ~ack_o;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (ce) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ST_ACCESS;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            if (!ce) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt <= 4'd1) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         ST_ACCESS: state_nxt = ce ? ST_DONE : ST_IDLE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         lat_we  <= 1'b0;
         lat_idx <= '0;
         lat_sel <= 4'd0;
         lat_dat <= 32'd0;
         data_o  <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_IDLE && ce) begin
            lat_we  <= we;
            lat_idx <= addr[ADDR_WIDTH+1:2];
            lat_sel <= sel;
            lat_dat <= data_i;
         end
         if (do_access && !lat_we) begin
            data_o <= {bank[3][lat_idx], bank[2][lat_idx], bank[1][lat_idx], bank[0][lat_idx]};
         end
      end
   end

   // Memory contents survive reset; a reset forces IDLE, which blocks any pending commit.
   always_ff @(posedge clk) begin
      if (do_access && lat_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_sel[i]) begin
               bank[i][lat_idx] <= lat_dat[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_ram_ws.sv
// Directed bench for data_ram_ws: default build (2 wait states) and a zero-wait build sharing the stimulus bus.
module tb_data_ram_ws;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce_a = 1'b0;
   logic        ce_b = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] data_i = 32'd0;
   logic [31:0] data_a, data_b;
   logic        ack_a, ack_b, stall_a, stall_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_ram_ws #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .ce(ce_a), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .data_o(data_a), .ack_o(ack_a), .stallreq_o(stall_a)
   );

   data_ram_ws #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .ce(ce_b), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .data_o(data_b), .ack_o(ack_b), .stallreq_o(stall_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // lat counts sampled half-cycles up to the ack: one before acceptance plus WAIT_CYCLES+2 after it.
   task automatic xact(input bit use_b, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] dv, input int lat, input string tag);
      int   n;
      logic got_ack, stall, stall_ok;
      @(posedge clk); #1;
      we = w; addr = a; sel = s; data_i = dv;
      if (use_b) ce_b = 1'b1; else ce_a = 1'b1;
      n = 0; got_ack = 1'b0; stall_ok = 1'b1;
      while (!got_ack && n < 30) begin
         @(negedge clk);
         n++;
         got_ack = use_b ? ack_b : ack_a;
         stall   = use_b ? stall_b : stall_a;
         if (stall !== !got_ack) stall_ok = 1'b0;
         if (n == 2) begin
            addr = a ^ 32'h20; data_i = ~dv; sel = ~s;
         end
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
      @(posedge clk); #1;
      ce_a = 1'b0; ce_b = 1'b0;
   endtask

   initial begin
      logic idle_ok;
      logic saw_ack;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1; chk("rst_data", data_a, 32'd0);
      chk("rst_ack", {31'd0, ack_a}, 32'd0);
      @(negedge clk); rst = 1'b1;
      idle_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ack_a !== 1'b0 || stall_a !== 1'b0 || data_a !== 32'd0 ||
             ack_b !== 1'b0 || stall_b !== 1'b0 || data_b !== 32'd0) idle_ok = 1'b0;
      end
      chk("idle", {31'd0, idle_ok}, 32'd1);

      // Full write then read
      xact(1'b0, 1'b1, 32'h0000_0008, 4'b1111, 32'h1234_5678, 5, "wr_full");
      chk("wr_keeps_data", data_a, 32'd0);
      xact(1'b0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 5, "rd_full");
      chk("rd_full_data", data_a, 32'h1234_5678);

      // Byte lanes
      xact(1'b0, 1'b1, 32'h0000_0008, 4'b0100, 32'hAABB_CCDD, 5, "wr_lane");
      xact(1'b0, 1'b0, 32'h0000_0008, 4'b0001, 32'h0, 5, "rd_lane");
      chk("rd_lane_data", data_a, 32'h12BB_5678);
      xact(1'b0, 1'b1, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 5, "wr_nosel");
      chk("wr_nosel_keeps_data", data_a, 32'h12BB_5678);
      xact(1'b0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 5, "rd_nosel");
      chk("rd_nosel_data", data_a, 32'h12BB_5678);

      // Abort: ce dropped in the second WAIT cycle
      xact(1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'h0102_0304, 5, "wr_pre");
      @(posedge clk); #1;
      we = 1'b1; addr = 32'h0000_0010; sel = 4'b1111; data_i = 32'hDEAD_BEEF; ce_a = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ce_a = 1'b0;
      saw_ack = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack_a) saw_ack = 1'b1;
      end
      chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);
      xact(1'b0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 5, "rd_abort");
      chk("rd_abort_data", data_a, 32'h0102_0304);

      // Reset during WAIT of a write
      xact(1'b0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 5, "rd_prerst");
      chk("rd_prerst_data", data_a, 32'h12BB_5678);
      @(posedge clk); #1;
      we = 1'b1; addr = 32'h0000_0008; sel = 4'b1111; data_i = 32'h0000_0000; ce_a = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_ack", {31'd0, ack_a}, 32'd0);
      chk("midrst_data", data_a, 32'd0);
      ce_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      xact(1'b0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0, 5, "rd_postrst");
      chk("rd_postrst_data", data_a, 32'h12BB_5678);

      // Zero-wait build with address aliasing
      xact(1'b1, 1'b1, 32'h0000_1004, 4'b1111, 32'h5A5A_5A5A, 3, "b_wr");
      xact(1'b1, 1'b0, 32'h0000_0004, 4'b1111, 32'h0, 3, "b_rd");
      chk("b_alias_data", data_b, 32'h5A5A_5A5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
